// File: rtl/piece_pkg.sv
//==============================================================================
// piece_pkg : shared piece types and constants for the piece queue
// Rev 1.0
//==============================================================================
`default_nettype none

package piece_pkg;

  typedef logic [2:0] piece_t;

  localparam piece_t PIECE_NONE = 3'd7;
  localparam int     NUM_PIECES = 7;
  localparam int     QDEPTH     = 4;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } q_state_t;

endpackage

`default_nettype wire

// File: rtl/piece_fifo.sv
//==============================================================================
// piece_fifo : circular buffer of pieces with indexed read of head, head+1, head+2
// Rev 1.0
//==============================================================================
`default_nettype none

module piece_fifo
  import piece_pkg::*;
#(
  parameter int DEPTH = QDEPTH,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  piece_t        din,
  output logic [CW-1:0] count,
  output piece_t        head_data,
  output piece_t        head1_data,
  output piece_t        head2_data
);

  localparam int            PW   = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  piece_t        r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          w_do_pop;
  logic          w_do_push;
  piece_t        w_rd [3];

  // Offsets never reach DEPTH, so one conditional subtract is enough to wrap.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  assign w_do_pop  = pop && (r_count != '0);
  assign w_do_push = push && ((r_count != FULL) || w_do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= PIECE_NONE;
    end else begin
      if (w_do_push) begin
        r_mem[r_tail] <= din;
        r_tail        <= wrap_add(r_tail, 1);
      end
      if (w_do_pop) r_head <= wrap_add(r_head, 1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_rd
    assign w_rd[k] = (r_count > CW'(k)) ? r_mem[wrap_add(r_head, k)] : PIECE_NONE;
  end

  assign count      = r_count;
  assign head_data  = w_rd[0];
  assign head1_data = w_rd[1];
  assign head2_data = w_rd[2];

endmodule

`default_nettype wire

// File: rtl/piece_queue.sv
//==============================================================================
// piece_queue : primed upcoming-piece queue with invalid/repeat filtering
// Rev 1.0
//==============================================================================
`default_nettype none

module piece_queue
  import piece_pkg::*;
#(
  parameter int DEPTH = QDEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] rand_piece,
  input  logic       take,
  output logic [2:0] next_piece,
  output logic       next_valid,
  output logic [2:0] preview_1,
  output logic [2:0] preview_2,
  output logic       underflow
);

  localparam int            CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  q_state_t      r_state;
  q_state_t      w_state_next;
  piece_t        r_last_pushed;
  logic          r_reroll_used;
  logic          r_underflow;
  logic [CW-1:0] w_count;
  logic          w_next_valid;
  logic          w_pop;
  logic          w_repeat;
  logic          w_cand_ok;
  logic          w_push;

  assign w_next_valid = (r_state == READY) && (w_count != '0);
  assign w_pop        = take && w_next_valid;
  assign w_repeat     = (rand_piece != PIECE_NONE) && (rand_piece == r_last_pushed);
  assign w_cand_ok    = (rand_piece != PIECE_NONE) && !(w_repeat && !r_reroll_used);
  assign w_push       = w_cand_ok && ((w_count != FULL) || w_pop);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= INIT;
    else      r_state <= w_state_next;
  end

  // No pops happen while priming, so the post-edge count is count + push.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      INIT:    if ((w_count + CW'(w_push)) == FULL) w_state_next = READY;
      READY:   w_state_next = READY;
      default: w_state_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_pushed <= PIECE_NONE;
      r_reroll_used <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_underflow <= take && !w_next_valid;
      if (w_push) begin
        r_last_pushed <= rand_piece;
        r_reroll_used <= 1'b0;
      end else if (w_repeat && !r_reroll_used) begin
        r_reroll_used <= 1'b1;
      end
    end
  end

  piece_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .din       (rand_piece),
    .count     (w_count),
    .head_data (next_piece),
    .head1_data(preview_1),
    .head2_data(preview_2)
  );

  assign next_valid = w_next_valid;
  assign underflow  = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_piece_queue.sv
//==============================================================================
// tb_piece_queue : directed scoreboard bench for piece_queue
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_piece_queue;
  import piece_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] rand_piece = 3'd7;
  logic       take = 1'b0;
  logic [2:0] next_piece;
  logic       next_valid;
  logic [2:0] preview_1;
  logic [2:0] preview_2;
  logic       underflow;

  piece_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .rand_piece(rand_piece),
    .take      (take),
    .next_piece(next_piece),
    .next_valid(next_valid),
    .preview_1 (preview_1),
    .preview_2 (preview_2),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    string      name;
    logic       nv;
    logic [2:0] np;
    logic [2:0] p1;
    logic [2:0] p2;
    logic       uf;
    logic [2:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic drive(input logic r, input logic [2:0] rp, input logic tk);
    rst        = r;
    rand_piece = rp;
    take       = tk;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic nv, input logic [2:0] np,
                            input logic [2:0] p1, input logic [2:0] p2,
                            input logic uf, input logic [2:0] cnt);
    exp_t x;
    x.at = cyc; x.name = name; x.nv = nv; x.np = np;
    x.p1 = p1;  x.p2 = p2;     x.uf = uf; x.cnt = cnt;
    sb.push_back(x);
  endtask

  // Monitor: compares outputs on the falling edge after the expected edge.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        vectors++;
        if (next_valid !== e.nv || next_piece !== e.np || preview_1 !== e.p1 ||
            preview_2 !== e.p2 || underflow !== e.uf || dut.u_fifo.count !== e.cnt) begin
          miscompares++;
          $display("FAIL %s: got nv=%0b np=%0d p1=%0d p2=%0d uf=%0b cnt=%0d, want nv=%0b np=%0d p1=%0d p2=%0d uf=%0b cnt=%0d",
                   e.name, next_valid, next_piece, preview_1, preview_2, underflow,
                   dut.u_fifo.count, e.nv, e.np, e.p1, e.p2, e.uf, e.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 7, 0);
    drive(0, 7, 0); expect_out("reset",        0, 7, 7, 7, 0, 0);

    // Priming
    drive(1, 0, 0); expect_out("prime0",       0, 0, 7, 7, 0, 1);
    drive(1, 1, 0); expect_out("prime1",       0, 0, 1, 7, 0, 2);
    drive(1, 2, 0); expect_out("prime2",       0, 0, 1, 2, 0, 3);
    drive(1, 3, 0); expect_out("prime3_ready", 1, 0, 1, 2, 0, 4);
    drive(1, 4, 0); expect_out("full_hold",    1, 0, 1, 2, 0, 4);

    // Full with simultaneous take
    drive(1, 5, 1); expect_out("full_swap",    1, 1, 2, 3, 0, 4);
    drive(1, 7, 1); expect_out("pop_inv",      1, 2, 3, 5, 0, 3);

    // Reroll
    drive(1, 5, 0); expect_out("reroll_disc",  1, 2, 3, 5, 0, 3);
    drive(1, 5, 0); expect_out("reroll_acc",   1, 2, 3, 5, 0, 4);
    drive(1, 5, 1); expect_out("reroll_pop",   1, 3, 5, 5, 0, 3);
    drive(1, 6, 0); expect_out("reroll_new",   1, 3, 5, 5, 0, 4);

    // Drain and underflow
    drive(1, 7, 1); expect_out("drain3",       1, 5, 5, 6, 0, 3);
    drive(1, 7, 1); expect_out("drain2",       1, 5, 6, 7, 0, 2);
    drive(1, 7, 1); expect_out("drain1",       1, 6, 7, 7, 0, 1);
    drive(1, 7, 1); expect_out("drain0",       0, 7, 7, 7, 0, 0);
    drive(1, 7, 1); expect_out("uflow_pulse",  0, 7, 7, 7, 1, 0);
    drive(1, 7, 0); expect_out("uflow_clear",  0, 7, 7, 7, 0, 0);

    // Refill stays READY
    drive(1, 2, 0); expect_out("refill1",      1, 2, 7, 7, 0, 1);
    drive(1, 4, 0); expect_out("refill2",      1, 2, 4, 7, 0, 2);
    drive(1, 6, 0); expect_out("refill3",      1, 2, 4, 6, 0, 3);
    drive(1, 1, 0); expect_out("refill4",      1, 2, 4, 6, 0, 4);

    // Mid-operation reset with take
    drive(0, 3, 1); expect_out("mid_reset",    0, 7, 7, 7, 0, 0);

    // Invalid filter during INIT
    drive(1, 7, 0); expect_out("inv_a",        0, 7, 7, 7, 0, 0);
    drive(1, 7, 0); expect_out("inv_b",        0, 7, 7, 7, 0, 0);
    drive(1, 4, 0); expect_out("inv_4",        0, 4, 7, 7, 0, 1);
    drive(1, 7, 0); expect_out("inv_c",        0, 4, 7, 7, 0, 1);
    drive(1, 5, 0); expect_out("inv_5",        0, 4, 5, 7, 0, 2);

    // Take while priming
    drive(1, 7, 1); expect_out("init_take_uf", 0, 4, 5, 7, 1, 2);
    drive(1, 7, 0); expect_out("init_uf_clr",  0, 4, 5, 7, 0, 2);

    // Repeat of 3 during priming
    drive(1, 3, 0); expect_out("rep3_push",    0, 4, 5, 3, 0, 3);
    drive(1, 3, 0); expect_out("rep3_disc",    0, 4, 5, 3, 0, 3);
    drive(1, 3, 0); expect_out("rep3_ready",   1, 4, 5, 3, 0, 4);

    // Pop order after wrap
    drive(1, 7, 1); expect_out("order1",       1, 5, 3, 3, 0, 3);
    drive(1, 7, 1); expect_out("order2",       1, 3, 3, 7, 0, 2);

    take = 1'b0;
    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
